// File: rtl/tt_um_unload.sv
// ---------------------------------------------------------------------------
// tt_um_unload
// Reads a ternary weight array back out as a stream of MAX_IN_LEN-bit beats.
// When start is seen in IDLE, the weight vector and the last row index R are
// copied into a snapshot. The block then presents one beat per accepted
// handshake. Beat c carries bit c of every lane. The stream covers
// (R+1)*WIDTH beats and ends with a one-cycle uo_done pulse.
//
// Optional feature macro: UNLOAD_PARITY_EN
//   defined   -> uo_parity is the registered XOR of the uo_output bits
//   undefined -> uo_parity is tied to 0
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset (works regardless of ena)
//   ena        clock enable; all state holds while low
//   start      request a readback (sampled only in IDLE)
//   ui_param   configuration; [MAX_OUT_BITS-1:0] = last row index R
//   ui_weights flat weight vector, lane i occupies bits
//              [i*MAX_OUT_LEN*WIDTH +: MAX_OUT_LEN*WIDTH]
//   ui_ready   downstream accepts the current beat
//   uo_output  current beat
//   uo_valid   uo_output holds a valid beat
//   uo_busy    readback in progress (SEND or DONE)
//   uo_done    one-cycle pulse after the last beat is accepted
//   uo_parity  beat parity (see macro above)
// ---------------------------------------------------------------------------
module tt_um_unload #(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8,
    parameter int WIDTH       = 2
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            ena,
    input  logic                                            start,
    input  logic [$clog2(MAX_IN_LEN)+$clog2(MAX_OUT_LEN)-1:0] ui_param,
    input  logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0]          ui_weights,
    input  logic                                            ui_ready,
    output logic [MAX_IN_LEN-1:0]                           uo_output,
    output logic                                            uo_valid,
    output logic                                            uo_busy,
    output logic                                            uo_done,
    output logic                                            uo_parity
);

    localparam int MAX_IN_BITS  = $clog2(MAX_IN_LEN);
    localparam int MAX_OUT_BITS = $clog2(MAX_OUT_LEN);
    localparam int WIDTH_BITS   = $clog2(WIDTH);
    localparam int W_TOTAL      = WIDTH * MAX_IN_LEN * MAX_OUT_LEN;
    localparam int C_BITS       = MAX_OUT_BITS + WIDTH_BITS;
    localparam int STRIDE       = MAX_OUT_LEN * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t                    r_state;
    logic [W_TOTAL-1:0]        r_snapshot;
    logic [MAX_OUT_BITS-1:0]   r_rowLast;
    logic [C_BITS-1:0]         r_c;

    logic [C_BITS-1:0]         w_cNext;
    logic [C_BITS-1:0]         w_lastC;
    logic                      w_isLast;
    logic                      w_startGo;
    logic                      w_accept;
    logic [MAX_IN_LEN-1:0]     w_firstBeat;
    logic [MAX_IN_LEN-1:0]     w_nextBeat;
    logic                      w_unusedParam;

    // Only the row field of ui_param matters here; the upper bits belong to
    // the loader's configuration.
    assign w_unusedParam = ^ui_param[MAX_IN_BITS+MAX_OUT_BITS-1:MAX_OUT_BITS];

    assign w_cNext   = r_c + 1'b1;
    // The last beat is the final weight bit of row R: {R, all ones}.
    assign w_lastC   = {r_rowLast, {WIDTH_BITS{1'b1}}};
    assign w_isLast  = (r_c == w_lastC);
    assign w_startGo = ena && (r_state == IDLE) && start;
    assign w_accept  = ena && (r_state == SEND) && ui_ready;

    // Beat 0 comes straight from ui_weights so it can be registered on the
    // same edge that takes the snapshot. Later beats come from the snapshot.
    for (genvar i = 0; i < MAX_IN_LEN; i++) begin : gLane
        logic [STRIDE-1:0] w_lane;
        assign w_lane         = r_snapshot[i*STRIDE +: STRIDE];
        assign w_firstBeat[i] = ui_weights[i*STRIDE];
        assign w_nextBeat[i]  = w_lane[w_cNext];
    end

    // The snapshot has no reset because its contents only matter during SEND.
    always_ff @(posedge clk) begin
        if (w_startGo) begin
            r_snapshot <= ui_weights;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rowLast <= '0;
            r_c       <= '0;
            uo_output <= '0;
            uo_valid  <= 1'b0;
            uo_busy   <= 1'b0;
            uo_done   <= 1'b0;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    uo_done <= 1'b0;
                    if (w_startGo) begin
                        r_rowLast <= ui_param[MAX_OUT_BITS-1:0];
                        r_c       <= '0;
                        uo_output <= w_firstBeat;
                        uo_valid  <= 1'b1;
                        uo_busy   <= 1'b1;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        if (w_isLast) begin
                            // Leave c on the last beat rather than wrapping.
                            uo_output <= '0;
                            uo_valid  <= 1'b0;
                            uo_done   <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_c       <= w_cNext;
                            uo_output <= w_nextBeat;
                        end
                    end
                end
                DONE: begin
                    uo_done <= 1'b0;
                    uo_busy <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef UNLOAD_PARITY_EN
    logic r_parity;

    // Parity tracks uo_output. It is loaded on the same events and cleared
    // when the stream ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_startGo) begin
            r_parity <= ^w_firstBeat;
        end else if (w_accept) begin
            r_parity <= w_isLast ? 1'b0 : ^w_nextBeat;
        end
    end

    assign uo_parity = r_parity;
`else
    assign uo_parity = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_unload.sv
// ---------------------------------------------------------------------------
// tb_tt_um_unload
// Directed, table-driven bench for tt_um_unload with default parameters.
// Each table row describes one readback: weights, R, an optional stall, an
// optional mid-stream tamper, and hand-computed expected beats. Two extra
// hand-written sequences cover reset behaviour.
// ---------------------------------------------------------------------------
module tb_tt_um_unload;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic [6:0]   ui_param;
    logic [255:0] ui_weights;
    logic         ui_ready;
    logic [15:0]  uo_output;
    logic         uo_valid;
    logic         uo_busy;
    logic         uo_done;
    logic         uo_parity;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] weights;
        logic [2:0]   rowLast;
        int           stallBeat;
        int           stallLen;
        bit           stallEna;
        int           tamperAt;
        int           expBeats;
        logic [15:0]  expFirst;
        logic [15:0]  expB1;
        logic [15:0]  expLast;
    } vec_t;

    vec_t         tbl[8];
    logic [255:0] wDistinct;

    tt_um_unload dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .ui_param  (ui_param),
        .ui_weights(ui_weights),
        .ui_ready  (ui_ready),
        .uo_output (uo_output),
        .uo_valid  (uo_valid),
        .uo_busy   (uo_busy),
        .uo_done   (uo_done),
        .uo_parity (uo_parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: beat c holds bit c of each 16-bit lane slice.
    function automatic logic [15:0] expBeat(input logic [255:0] w, input int c);
        logic [15:0] b;
        for (int i = 0; i < 16; i++) b[i] = w[i*16 + c];
        return b;
    endfunction

    function automatic logic expParity(input logic [15:0] b);
`ifdef UNLOAD_PARITY_EN
        return ^b;
`else
        return 1'b0 & b[0];
`endif
    endfunction

    // Builds a weight vector whose beat c is 16'h1000 + c*16'h0101.
    function automatic logic [255:0] mkWeights();
        logic [255:0] w;
        logic [15:0]  b;
        w = '0;
        for (int c = 0; c < 16; c++) begin
            b = 16'h1000 + 16'(c) * 16'h0101;
            for (int i = 0; i < 16; i++) w[i*16 + c] = b[i];
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one readback described by a table row and checks every sample.
    task automatic applyStimulus(input vec_t v);
        int          idx = 0;
        int          stallLeft;
        int          stallSeen = 0;
        int          tamperLeft = 0;
        bit          tampered = 0;
        bit          finished = 0;
        logic [15:0] first = '0;
        logic [15:0] b1 = '0;
        logic [15:0] last = '0;
        logic [15:0] expv;
        stallLeft  = v.stallLen;
        ui_weights = v.weights;
        ui_param   = 7'(v.rowLast);
        ui_ready   = 1'b1;
        ena        = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 80 && !finished; cyc++) begin
            if (uo_valid) begin
                expv = expBeat(v.weights, idx);
                checkOutput("beat", 32'(uo_output), 32'(expv));
                checkOutput("parity", 32'(uo_parity), 32'(expParity(expv)));
                checkOutput("busyInSend", 32'(uo_busy), 32'd1);
                if (idx == 0) first = uo_output;
                if (idx == 1) b1 = uo_output;
                last = uo_output;
                if (idx == v.stallBeat) stallSeen++;
                if (tamperLeft > 0) begin
                    tamperLeft--;
                    if (tamperLeft == 0) start = 1'b0;
                end
                if (idx == v.tamperAt && !tampered) begin
                    tampered   = 1'b1;
                    ui_weights = ~v.weights;
                    ui_param   = '0;
                    start      = 1'b1;
                    tamperLeft = 3;
                end
                if (idx == v.stallBeat && stallLeft > 0) begin
                    stallLeft--;
                    if (v.stallEna) begin
                        ena = 1'b0;
                        ui_ready = 1'b1;
                    end else begin
                        ena = 1'b1;
                        ui_ready = 1'b0;
                    end
                end else begin
                    ena = 1'b1;
                    ui_ready = 1'b1;
                    idx++;
                end
            end else if (uo_done) begin
                checkOutput("doneBusy", 32'(uo_busy), 32'd1);
                checkOutput("beatCount", 32'(idx), 32'(v.expBeats));
                checkOutput("firstBeat", 32'(first), 32'(v.expFirst));
                checkOutput("beat1", 32'(b1), 32'(v.expB1));
                checkOutput("lastBeat", 32'(last), 32'(v.expLast));
                if (v.stallBeat >= 0)
                    checkOutput("stallHold", 32'(stallSeen), 32'(v.stallLen + 1));
                // start during the DONE->IDLE edge must be ignored
                start = 1'b1;
                tick();
                checkOutput("donePulseOnce", 32'(uo_done), 32'd0);
                checkOutput("idleBusy", 32'(uo_busy), 32'd0);
                checkOutput("idleValid", 32'(uo_valid), 32'd0);
                start = 1'b0;
                finished = 1'b1;
            end else begin
                checks++;
                errors++;
                $display("[TB] FAIL streamGap: valid=0 done=0 at beat %0d, required an active stream", idx);
                finished = 1'b1;
            end
            if (!finished) tick();
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: no done pulse after 80 cycles, beat %0d", idx);
        end
        start = 1'b0;
        ena = 1'b1;
        ui_ready = 1'b1;
        tick();
    endtask

    initial begin
        wDistinct = mkWeights();
        //            weights                   R     stB  stL en  tmp  n   first     b1        last
        tbl[0] = '{256'h2_0000,             3'd7, -1, 0, 1'b0, -1, 16, 16'h0000, 16'h0002, 16'h0000};
        tbl[1] = '{{256{1'b1}},             3'd0, -1, 0, 1'b0, -1,  2, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tbl[2] = '{{16{16'h0001}},          3'd3, -1, 0, 1'b0, -1,  8, 16'hFFFF, 16'h0000, 16'h0000};
        tbl[3] = '{256'h1_0003_0003,        3'd0, -1, 0, 1'b0, -1,  2, 16'h0007, 16'h0003, 16'h0003};
        tbl[4] = '{{16{16'h0005}},          3'd1, -1, 0, 1'b0, -1,  4, 16'hFFFF, 16'h0000, 16'h0000};
        tbl[5] = '{wDistinct,               3'd7,  4, 3, 1'b0, -1, 16, 16'h1000, 16'h1101, 16'h1F0F};
        tbl[6] = '{wDistinct,               3'd7,  4, 3, 1'b1, -1, 16, 16'h1000, 16'h1101, 16'h1F0F};
        tbl[7] = '{wDistinct,               3'd5, -1, 0, 1'b0,  3, 12, 16'h1000, 16'h1101, 16'h1B0B};

        // Reset with ena low and start high must still clear everything.
        rst_n = 1'b0;
        ena = 1'b0;
        start = 1'b1;
        ui_param = '0;
        ui_weights = '0;
        ui_ready = 1'b1;
        tick();
        tick();
        checkOutput("rstValid", 32'(uo_valid), 32'd0);
        checkOutput("rstBusy", 32'(uo_busy), 32'd0);
        checkOutput("rstDone", 32'(uo_done), 32'd0);
        checkOutput("rstOutput", 32'(uo_output), 32'd0);
        checkOutput("rstParity", 32'(uo_parity), 32'd0);
        start = 1'b0;
        ena = 1'b1;
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 8; t++) begin
            $display("[TB] vector %0d", t);
            applyStimulus(tbl[t]);
        end

        // Reset during beat 5 aborts the stream without a done pulse.
        ui_weights = wDistinct;
        ui_param = 7'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checkOutput("preResetBeat5", 32'(uo_output), 32'h1505);
        rst_n = 1'b0;
        tick();
        checkOutput("abortValid", 32'(uo_valid), 32'd0);
        checkOutput("abortBusy", 32'(uo_busy), 32'd0);
        checkOutput("abortDone", 32'(uo_done), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("noDoneAfterAbort", 32'({uo_done, uo_busy}), 32'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restartValid", 32'(uo_valid), 32'd1);
        checkOutput("restartBeat0", 32'(uo_output), 32'h1000);
        tick();
        checkOutput("restartBeat1", 32'(uo_output), 32'h1101);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_unload.md
TT_UM_UNLOAD -- requirements
Module: tt_um_unload

Interface
REQ-001 SHALL have parameter MAX_IN_LEN, default 16: lanes per beat; each lane carries one weight bit.
REQ-002 SHALL have parameter MAX_OUT_LEN, default 8: maximum output rows.
REQ-003 SHALL have parameter WIDTH, default 2: bits per ternary weight.
REQ-004 SHALL derive the following from these parameters: MAX_IN_BITS = clog2(MAX_IN_LEN), MAX_OUT_BITS = clog2(MAX_OUT_LEN), WIDTH_BITS = clog2(WIDTH), W_TOTAL = WIDTH*MAX_IN_LEN*MAX_OUT_LEN.
REQ-005 SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port ena, input, 1 bit: enable; when low, all state holds.
REQ-008 SHALL have port start, input, 1 bit: request a readback.
REQ-009 SHALL have port ui_param, input, MAX_IN_BITS+MAX_OUT_BITS bits: configuration; bits [MAX_OUT_BITS-1:0] hold the last row index R.
REQ-010 SHALL have port ui_weights, input, W_TOTAL bits: flat weight vector in the same layout the loader writes.
REQ-011 SHALL have port ui_ready, input, 1 bit: downstream accepts the current beat.
REQ-012 SHALL have port uo_output, output, MAX_IN_LEN bits: serialized beat.
REQ-013 SHALL have port uo_valid, output, 1 bit: uo_output holds a valid beat.
REQ-014 SHALL have port uo_busy, output, 1 bit: a readback is in progress.
REQ-015 SHALL have port uo_done, output, 1 bit: one-cycle pulse after the last beat is accepted.
REQ-016 SHALL have port uo_parity, output, 1 bit: beat parity (see Configuration).

Function
REQ-017 SHALL implement the states IDLE, SEND and DONE, and all outputs SHALL be registered.
REQ-018 In IDLE with ena=1 and start=1, the block SHALL capture ui_weights into a snapshot register, capture R from ui_param, clear beat counter c to 0 and go to SEND.
REQ-019 In SEND, uo_output[i] SHALL equal snapshot[{i, c}], i.e. bit index i*(MAX_OUT_LEN*WIDTH)+c, for i = 0..MAX_IN_LEN-1.
REQ-020 Beat 0 SHALL be presented with uo_valid=1 in the first cycle after start is sampled (latency 1).
REQ-021 A beat SHALL be consumed on an edge with ena=1, uo_valid=1 and ui_ready=1; c SHALL then increment and the next beat SHALL appear on the following cycle.
REQ-022 When ui_ready=0 or ena=0, uo_output, uo_valid and c SHALL hold unchanged.
REQ-023 c SHALL be MAX_OUT_BITS+WIDTH_BITS bits wide; the last beat SHALL be c = {R, all-ones(WIDTH_BITS)}, giving a beat count of (R+1)*WIDTH.
REQ-024 Acceptance of the last beat SHALL cause a transition to DONE; in DONE, uo_valid=0 and uo_done=1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-025 uo_busy SHALL be 1 in SEND and DONE, and 0 in IDLE.
REQ-026 start while in SEND or DONE SHALL be ignored, with no restart.
REQ-027 Changes to ui_weights or ui_param during SEND SHALL not affect the output, since the snapshot and R are used.
REQ-028 A start in the same cycle that DONE returns to IDLE SHALL be ignored; start SHALL be sampled only in IDLE.
REQ-029 R = MAX_OUT_LEN-1 SHALL read the whole array, and c SHALL not wrap past the last beat.

Reset
REQ-030 On rst_n=0 at a clock edge, the block SHALL return to IDLE with c=0, uo_output=0, uo_valid=0, uo_busy=0, uo_done=0 and uo_parity=0, regardless of ena.
REQ-031 Reset in mid-SEND SHALL abort the readback with no uo_done pulse, and the snapshot contents SHALL be don't-care.

Configuration
REQ-032 With macro UNLOAD_PARITY_EN defined, uo_parity SHALL be a registered XOR of all uo_output bits, valid together with uo_valid and held with it.
REQ-033 Without UNLOAD_PARITY_EN, uo_parity SHALL be constant 0 and the parity logic SHALL be absent.

Verification
REQ-034 Defaults, ui_weights bit 17 only set, R=7, start pulse, ui_ready=1 -> 16 beats; beat 1 = 16'h0002, all other beats 0; uo_done high in the cycle after beat 15.
REQ-035 R=0, ui_weights all ones -> exactly 2 beats of 16'hFFFF, then a uo_done pulse, then uo_busy=0.
REQ-036 ui_ready low for 3 cycles during beat 4 -> beat 4 held stable for 4 cycles, with no beat skipped or duplicated.
REQ-037 rst_n low during beat 5 -> uo_valid, uo_busy and uo_done all 0 on the next cycle; no done pulse; a subsequent start restarts at beat 0.
REQ-038 With UNLOAD_PARITY_EN, beat 16'h0007 -> uo_parity=1; beat 16'h0003 -> uo_parity=0. Without the macro -> uo_parity=0 throughout.
REQ-039 ui_weights modified and start re-asserted mid-SEND -> output stream matches the original snapshot, and no restart occurs.
